// File: rtl/mem_wb_skid_reg_if.sv
// MEM/WB boundary bundle: upstream entry handshake, downstream write-back handshake,
// forwarding tap and occupancy. slave = the skid register, master = its environment.
interface mem_wb_skid_reg_if #(
  parameter int LEN_REGISTER = 32,
  parameter int LEN_REG_ADDR = 4
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic                    wb_en_in;
  logic                    mem_read_in;
  logic [LEN_REG_ADDR-1:0] dest_in;
  logic [LEN_REGISTER-1:0] alu_result_in;
  logic [LEN_REGISTER-1:0] mem_data_in;

  logic                    out_valid;
  logic                    out_ready;
  logic                    wb_en_out;
  logic [LEN_REG_ADDR-1:0] dest_out;
  logic [LEN_REGISTER-1:0] wb_value_out;

  logic                    fwd_en;
  logic [LEN_REG_ADDR-1:0] fwd_dest;
  logic [LEN_REGISTER-1:0] fwd_value;
  logic [1:0]              count;

  modport master (
    output flush, in_valid, wb_en_in, mem_read_in, dest_in, alu_result_in, mem_data_in,
    output out_ready,
    input  in_ready, out_valid, wb_en_out, dest_out, wb_value_out,
    input  fwd_en, fwd_dest, fwd_value, count
  );

  modport slave (
    input  flush, in_valid, wb_en_in, mem_read_in, dest_in, alu_result_in, mem_data_in,
    input  out_ready,
    output in_ready, out_valid, wb_en_out, dest_out, wb_value_out,
    output fwd_en, fwd_dest, fwd_value, count
  );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register as a 2-entry skid buffer. The write-back value is selected
// at capture; every output is decoded from flops so out_ready never reaches in_ready.
module mem_wb_skid_reg #(
  parameter int LEN_REGISTER = 32,
  parameter int LEN_REG_ADDR = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_wb_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic                    wb_en;
    logic [LEN_REG_ADDR-1:0] dest;
    logic [LEN_REGISTER-1:0] value;
  } slot_t;

  state_e state_q, state_d;
  slot_t  head_q, head_d;
  slot_t  tail_q, tail_d;
  slot_t  in_slot;
  slot_t  fwd_slot;
  logic   push;
  logic   pop;

  // Ready/valid come from the state register alone, never from the other side's handshake.
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  assign in_slot.wb_en = bus.wb_en_in;
  assign in_slot.dest  = bus.dest_in;
  assign in_slot.value = bus.mem_read_in ? bus.mem_data_in : bus.alu_result_in;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = in_slot;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = FULL;
            tail_d  = in_slot;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            head_d = in_slot;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: the two slots are only a few flops and the reset state must show all-zero outputs,
  // so they are reset along with the state, unlike a real memory array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values regardless of order.
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // The youngest held entry is the one a dependent instruction must see.
  always_comb begin
    fwd_slot = '0;
    unique case (state_q)
      FULL:    fwd_slot = tail_q;
      ONE:     fwd_slot = head_q;
      default: fwd_slot = '0;
    endcase
  end

  assign bus.wb_en_out    = head_q.wb_en;
  assign bus.dest_out     = head_q.dest;
  assign bus.wb_value_out = head_q.value;
  assign bus.fwd_en       = fwd_slot.wb_en;
  assign bus.fwd_dest     = fwd_slot.dest;
  assign bus.fwd_value    = fwd_slot.value;
  assign bus.count        = state_q;

endmodule
